dht11_ctrl: RTL and testbench



---
 rtl/dht11_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dht11_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_ctrl.sv
// DHT11 single-wire controller: host start pulse, 40-bit frame decode, integer RH/T output.
// Optional build macro DHT11_CHECKSUM_EN enables checksum verification in CHECK.
module dht11_ctrl #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 100,
    parameter int BIT_THRESH_US = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    inout  wire         dht11_io,
    output logic [15:0] dht11_data,
    output logic        done,
    output logic        error,
    output logic        busy
);

    localparam int DIV   = (CLK_FREQ / 1_000_000 > 0) ? (CLK_FREQ / 1_000_000) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_LOW = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RESP_LOW  = 3'd3,
        ST_RESP_HIGH = 3'd4,
        ST_BIT_LOW   = 3'd5,
        ST_BIT_HIGH  = 3'd6,
        ST_CHECK     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic [DIV_W-1:0]   div_q;
    logic [14:0]        us_q;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [39:0]        shift_q, shift_d;
    logic [15:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               busy_q;
    logic               drive_q;
    logic               tick_s;
    logic               rise_s;
    logic               fall_s;
    logic [15:0]        elapsed_s;
    logic               timeout_s;

    function automatic logic [7:0] frame_sum(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

    assign tick_s    = (div_q == DIV_W'(DIV - 1));
    assign rise_s    = sync_q[1] & ~prev_q;
    assign fall_s    = ~sync_q[1] & prev_q;
    // Ticks elapsed in the current state, counting the tick of this cycle.
    assign elapsed_s = {1'b0, us_q} + {15'd0, tick_s};
    assign timeout_s = (elapsed_s >= 16'(TIMEOUT_US));

    // Open-drain pad: only ever pulled low, released at once by reset.
    assign dht11_io   = (drive_q && !reset) ? 1'b0 : 1'bz;
    assign dht11_data = data_q;
    assign done       = done_q;
    assign error      = error_q;
    assign busy       = busy_q;

    // Next-state, frame shifting and result capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A request coinciding with a result pulse is dropped.
                if (start && !done_q && !error_q) begin
                    state_d = ST_START_LOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START_LOW: begin
                if (elapsed_s >= 16'(START_LOW_US)) begin
                    state_d = ST_WAIT_RESP;
                end else begin
                    state_d = ST_START_LOW;
                end
            end
            ST_WAIT_RESP, ST_RESP_HIGH: begin
                if (timeout_s) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else if (fall_s) begin
                    state_d   = (state_q == ST_WAIT_RESP) ? ST_RESP_LOW : ST_BIT_LOW;
                    bit_cnt_d = (state_q == ST_WAIT_RESP) ? bit_cnt_q : 6'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESP_LOW, ST_BIT_LOW: begin
                if (timeout_s) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else if (rise_s) begin
                    state_d = (state_q == ST_RESP_LOW) ? ST_RESP_HIGH : ST_BIT_HIGH;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BIT_HIGH: begin
                if (timeout_s) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end else if (fall_s) begin
                    shift_d   = {shift_q[38:0], (elapsed_s > 16'(BIT_THRESH_US))};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd39) ? ST_CHECK : ST_BIT_LOW;
                end else begin
                    state_d = ST_BIT_HIGH;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
`ifdef DHT11_CHECKSUM_EN
                if (frame_sum(shift_q) == shift_q[7:0]) begin
                    done_d = 1'b1;
                    data_d = {shift_q[39:32], shift_q[23:16]};
                end else begin
                    error_d = 1'b1;
                end
`else
                done_d = 1'b1;
                data_d = {shift_q[39:32], shift_q[23:16]};
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, synchronizer, tick divider, µs counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            div_q     <= '0;
            us_q      <= 15'd0;
            bit_cnt_q <= 6'd0;
            shift_q   <= 40'd0;
            data_q    <= 16'h0000;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            drive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], dht11_io};
            prev_q    <= sync_q[1];
            div_q     <= tick_s ? '0 : div_q + DIV_W'(1);
            if (state_d != state_q) begin
                us_q <= 15'd0;
            end else if (tick_s && (us_q != 15'h7FFF)) begin
                us_q <= us_q + 15'd1;
            end else begin
                us_q <= us_q;
            end
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= (state_d != ST_IDLE);
            drive_q   <= (state_d == ST_START_LOW);
        end
    end

endmodule

// File: tb/tb_dht11_ctrl.sv
// Bench for dht11_ctrl: behavioural DHT11 sensor on a pulled-up line, directed and random frames.
module tb_dht11_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sensor_low = 1'b0;
    wire         dht11_line;
    logic [15:0] dht_data;
    logic        dht_done;
    logic        dht_error;
    logic        dht_busy;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int busy_pulse_cnt = 0;
    int data_glitch = 0;
    bit mon_en = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    logic [15:0] exp_data = 16'h0000;

    assign dht11_line = sensor_low ? 1'b0 : 1'bz;
    pullup (dht11_line);

    always #5 clk = ~clk;

    dht11_ctrl #(
        .CLK_FREQ(1_000_000),
        .START_LOW_US(50),
        .TIMEOUT_US(100),
        .BIT_THRESH_US(40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dht11_io(dht11_line),
        .dht11_data(dht_data),
        .done(dht_done),
        .error(dht_error),
        .busy(dht_busy)
    );

    // Pulse bookkeeping, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (dht_done === 1'b1) done_cnt++;
            if (dht_error === 1'b1) err_cnt++;
            if (dht_done === 1'b1 && dht_error === 1'b1) both_cnt++;
            if ((dht_done === 1'b1 || dht_error === 1'b1) && dht_busy !== 1'b0) busy_pulse_cnt++;
            if (reset === 1'b0 && dht_done !== 1'b1 && dht_data !== prev_data) data_glitch++;
        end
        prev_data = dht_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] mk_frame(input int rh, input int rhd, input int t, input int td,
                                             input int csum_adj);
        int s;
        s = (rh + rhd + t + td + csum_adj) % 256;
        return {8'(rh), 8'(rhd), 8'(t), 8'(td), 8'(s)};
    endfunction

    // Issue a read and measure the host low pulse; ends on the first released sample.
    task automatic issue_start();
        int low_cnt;
        @(negedge clk);
        check("busy_before_start", 32'(dht_busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(dht_busy), 32'd1);
        low_cnt = 0;
        while (dht11_line === 1'b0 && low_cnt < 20000) begin
            low_cnt++;
            @(negedge clk);
        end
        check("start_low_len", 32'(low_cnt), 32'd50);
    endtask

    // mode 1: 26/70 µs highs, mode 2: 40/41 µs highs, otherwise random widths.
    task automatic run_frame(input logic [39:0] frame, input int mode, input int abort_bit,
                             input bit poke_busy, input bit poke_done);
        int w[40];
        logic [39:0] dec;
        int s;
        bit acc;
        int d0, e0, lat;
        for (int i = 0; i < 40; i++) begin
            if (frame[39-i]) w[i] = (mode == 1) ? 70 : (mode == 2) ? 41 : int'($urandom_range(75, 41));
            else             w[i] = (mode == 1) ? 26 : (mode == 2) ? 40 : int'($urandom_range(40, 20));
        end
        dec = 40'd0;
        for (int i = 0; i < 40; i++) dec = {dec[38:0], (w[i] > 40)};
        s = int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8]);
`ifdef DHT11_CHECKSUM_EN
        acc = ((s % 256) == int'(dec[7:0]));
`else
        acc = 1'b1;
`endif
        d0 = done_cnt;
        e0 = err_cnt;
        issue_start();
        repeat (30) @(negedge clk);
        sensor_low = 1'b1;
        repeat (80) @(negedge clk);
        sensor_low = 1'b0;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i == abort_bit) begin
                sensor_low = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                check("abort_busy", 32'(dht_busy), 32'd0);
                check("abort_line", 32'(dht11_line), 32'd1);
                check("abort_pulses", {30'd0, dht_done, dht_error}, 32'd0);
                check("abort_data", 32'(dht_data), 32'h0000);
                reset = 1'b0;
                exp_data = 16'h0000;
                repeat (20) @(negedge clk);
                check("abort_no_done", 32'(done_cnt - d0), 32'd0);
                check("abort_no_error", 32'(err_cnt - e0), 32'd0);
                return;
            end
            sensor_low = 1'b1;
            if (poke_busy && i == 10) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (49) @(negedge clk);
            sensor_low = 1'b0;
            repeat (w[i]) @(negedge clk);
        end
        sensor_low = 1'b1;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if ((dht_done === 1'b1 || dht_error === 1'b1) && lat == 0) begin
                lat = k;
                check("busy_at_pulse", 32'(dht_busy), 32'd0);
                if (poke_done) start = 1'b1;
            end
        end
        start = 1'b0;
        sensor_low = 1'b0;
        repeat (20) @(negedge clk);
        if (acc) exp_data = {dec[39:32], dec[23:16]};
        check("pulse_latency", 32'(lat), 32'd4);
        check("done_count", 32'(done_cnt - d0), 32'(acc));
        check("error_count", 32'(err_cnt - e0), 32'(!acc));
        check("frame_data", 32'(dht_data), 32'(exp_data));
        check("idle_busy", 32'(dht_busy), 32'd0);
        check("idle_line", 32'(dht11_line), 32'd1);
    endtask

    initial begin
        int n, d0, e0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(dht_data), 32'h0000);
        check("rst_done", 32'(dht_done), 32'd0);
        check("rst_error", 32'(dht_error), 32'd0);
        check("rst_busy", 32'(dht_busy), 32'd0);
        check("rst_line", 32'(dht11_line), 32'd1);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        run_frame(mk_frame(45, 0, 23, 0, 0), 1, 99, 1'b0, 1'b0);
        check("nominal_data", 32'(dht_data), 32'h2D17);
        run_frame(mk_frame(45, 0, 23, 0, 1), 1, 99, 1'b0, 1'b0);

        // Silent sensor: error exactly TIMEOUT_US cycles after release.
        d0 = done_cnt;
        e0 = err_cnt;
        issue_start();
        n = 0;
        while (n < 300 && dht_error !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd100);
        check("timeout_busy", 32'(dht_busy), 32'd0);
        check("timeout_data", 32'(dht_data), 32'(exp_data));
        repeat (10) @(negedge clk);
        check("timeout_errors", 32'(err_cnt - e0), 32'd1);
        check("timeout_dones", 32'(done_cnt - d0), 32'd0);

        run_frame(mk_frame(165, 0, 90, 0, 0), 2, 99, 1'b0, 1'b0);
        run_frame(mk_frame(90, 0, 165, 0, 0), 2, 99, 1'b0, 1'b0);

        for (int f = 0; f < 5; f++) begin
            run_frame(mk_frame(int'($urandom_range(95, 5)), int'($urandom_range(9, 0)),
                               int'($urandom_range(50, 0)), int'($urandom_range(9, 0)), 0),
                      0, 99, 1'b0, 1'b0);
        end
        for (int f = 0; f < 2; f++) begin
            run_frame(mk_frame(int'($urandom_range(95, 5)), 0, int'($urandom_range(50, 0)), 0,
                               int'($urandom_range(255, 1))), 0, 99, 1'b0, 1'b0);
        end

        run_frame(mk_frame(60, 0, 30, 0, 0), 0, 19, 1'b0, 1'b0);
        run_frame(mk_frame(45, 0, 23, 0, 0), 1, 99, 1'b0, 1'b0);
        run_frame(mk_frame(int'($urandom_range(95, 5)), 0, int'($urandom_range(50, 0)), 0, 0),
                  0, 99, 1'b1, 1'b1);

        check("never_both", 32'(both_cnt), 32'd0);
        check("busy_low_on_pulse", 32'(busy_pulse_cnt), 32'd0);
        check("data_only_on_done", 32'(data_glitch), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
